vliw_lsu: RTL and testbench

- Load/store unit placed directly downstream of the three VLIW execution units.
- Consumes each bundle's per-slot loadstore requests (address, size, sign-extend, destination register, store data).
- Serialises the requests in slot order onto a single word-wide memory handshake port.
- Returns load results as register-writeback pulses. Asserts busy so the core stalls issue until the bundle's memory traffic completes.

---
 rtl/vliw_lsu_pkg.sv | 24 ++
 rtl/vliw_lsu_if.sv | 20 ++
 rtl/vliw_lsu_lane_align.sv | 52 +++++
 rtl/vliw_lsu.sv | 149 ++++++++++++++
 tb/tb_vliw_lsu.sv | 351 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vliw_lsu_pkg.sv
// Shared encodings for the VLIW load/store unit: access sizes, FSM states,
// default ack timeout and the per-slot alignment legality check.
package vliw_lsu_pkg;

  localparam logic [1:0] SZ_BYTE    = 2'd0;
  localparam logic [1:0] SZ_HALF    = 2'd1;
  localparam logic [1:0] SZ_WORD    = 2'd2;
  localparam logic [1:0] SZ_ILLEGAL = 2'd3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_NEXT  = 2'd2;

  localparam int ACK_TIMEOUT_DEF = 255;

  // A slot is dropped when its size is illegal or its address is not
  // naturally aligned for the access size.
  function automatic logic slot_bad(input logic [1:0] size, input logic [1:0] addr_lo);
    return (size == SZ_HALF && addr_lo[0]) ||
           (size == SZ_WORD && addr_lo != 2'b00) ||
           (size == SZ_ILLEGAL);
  endfunction

endpackage

// File: rtl/vliw_lsu_if.sv
// Word-wide memory request/acknowledge port between the LSU and memory.
interface vliw_lsu_if;
  logic        mem_req;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/vliw_lsu_lane_align.sv
// Byte-lane steering: store mask/replication and load extraction/extension.
module lsu_lane_align
  import vliw_lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        sext,
  input  logic [31:0] st_data,
  input  logic [31:0] rdata,
  output logic [3:0]  wmask,
  output logic [31:0] wdata,
  output logic [31:0] ld_data
);

  function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic sx);
    logic signed [7:0] sb;
    sb = b;
    return sx ? 32'(sb) : {24'h0, b};
  endfunction

  function automatic logic [31:0] ext_half(input logic [15:0] h, input logic sx);
    logic signed [15:0] sh;
    sh = h;
    return sx ? 32'(sh) : {16'h0, h};
  endfunction

  logic [7:0]  ld_b;
  logic [15:0] ld_h;

  assign ld_b = rdata[{addr_lo, 3'b000} +: 8];
  assign ld_h = rdata[{addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    wmask   = 4'b1111;
    wdata   = st_data;
    ld_data = rdata;
    case (size)
      SZ_BYTE: begin
        wmask   = 4'b0001 << addr_lo;
        wdata   = {4{st_data[7:0]}};
        ld_data = ext_byte(ld_b, sext);
      end
      SZ_HALF: begin
        wmask   = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata   = {2{st_data[15:0]}};
        ld_data = ext_half(ld_h, sext);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/vliw_lsu.sv
// VLIW load/store unit: latches a bundle's slot requests and serialises them
// in slot order onto one memory port, returning loads as writeback pulses.
module vliw_lsu
  import vliw_lsu_pkg::*;
#(
  parameter int NUM_SLOTS   = 3,
  parameter int REG_IDX_W   = 5,
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic                           wb_clk_i,
  input  logic                           rst_n,
  input  logic [NUM_SLOTS-1:0]           req_valid,
  input  logic [NUM_SLOTS-1:0]           req_we,
  input  logic [NUM_SLOTS*32-1:0]        req_addr,
  input  logic [NUM_SLOTS*32-1:0]        req_wdata,
  input  logic [NUM_SLOTS*2-1:0]         req_size,
  input  logic [NUM_SLOTS-1:0]           req_sext,
  input  logic [NUM_SLOTS*REG_IDX_W-1:0] req_dest,
  output logic                           busy,
  vliw_lsu_if.master                     mem,
  output logic                           wb_valid,
  output logic [REG_IDX_W-1:0]           wb_idx,
  output logic [31:0]                    wb_data,
  output logic                           misalign_err,
  output logic                           timeout_err
);

  localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int TMO_W  = $clog2(ACK_TIMEOUT + 1);

  logic [1:0]                     state;
  logic [NUM_SLOTS-1:0]           pending;
  logic [TMO_W-1:0]               tmo_cnt;
  logic [NUM_SLOTS-1:0]           we_q, sext_q;
  logic [NUM_SLOTS*32-1:0]        addr_q, wdata_q;
  logic [NUM_SLOTS*2-1:0]         size_q;
  logic [NUM_SLOTS*REG_IDX_W-1:0] dest_q;

  logic [NUM_SLOTS-1:0] bad;
  logic [SLOT_W-1:0]    cur;
  logic                 accept, issuing;
  logic                 cur_we, cur_sext;
  logic [31:0]          cur_addr, cur_wdata;
  logic [1:0]           cur_size;
  logic [REG_IDX_W-1:0] cur_dest;
  logic [3:0]           lane_wmask;
  logic [31:0]          lane_wdata, lane_ld;

  always_comb begin
    bad = '0;
    for (int s = 0; s < NUM_SLOTS; s++)
      bad[s] = slot_bad(req_size[2*s +: 2], req_addr[32*s +: 2]);
  end

  // Lowest pending slot goes first, which keeps same-address accesses in order.
  always_comb begin
    cur = '0;
    for (int s = NUM_SLOTS - 1; s >= 0; s--)
      if (pending[s]) cur = SLOT_W'(s);
  end

  assign accept    = (state == ST_IDLE) && (|req_valid);
  assign issuing   = (state == ST_ISSUE);
  assign busy      = (state != ST_IDLE);
  assign cur_we    = we_q[cur];
  assign cur_sext  = sext_q[cur];
  assign cur_addr  = addr_q[cur*32 +: 32];
  assign cur_wdata = wdata_q[cur*32 +: 32];
  assign cur_size  = size_q[cur*2 +: 2];
  assign cur_dest  = dest_q[cur*REG_IDX_W +: REG_IDX_W];

  lsu_lane_align u_align (
    .size    (cur_size),
    .addr_lo (cur_addr[1:0]),
    .sext    (cur_sext),
    .st_data (cur_wdata),
    .rdata   (mem.mem_rdata),
    .wmask   (lane_wmask),
    .wdata   (lane_wdata),
    .ld_data (lane_ld)
  );

  assign mem.mem_req   = issuing;
  assign mem.mem_we    = issuing & cur_we;
  assign mem.mem_addr  = issuing ? cur_addr[31:2] : '0;
  assign mem.mem_wdata = (issuing & cur_we) ? lane_wdata : '0;
  assign mem.mem_wmask = (issuing & cur_we) ? lane_wmask : '0;

  // Bundle capture: slot fields are only meaningful while pending bits are set.
  always_ff @(posedge wb_clk_i) begin
    if (accept) begin
      we_q    <= req_we;
      sext_q  <= req_sext;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      size_q  <= req_size;
      dest_q  <= req_dest;
    end
  end

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      pending      <= '0;
      tmo_cnt      <= '0;
      wb_valid     <= 1'b0;
      wb_idx       <= '0;
      wb_data      <= '0;
      misalign_err <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      wb_valid     <= 1'b0;
      misalign_err <= 1'b0;
      timeout_err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            pending      <= req_valid & ~bad;
            misalign_err <= |(req_valid & bad);
            state        <= (|(req_valid & ~bad)) ? ST_ISSUE : ST_IDLE;
          end
        end
        ST_ISSUE: begin
          if (mem.mem_ack) begin
            pending[cur] <= 1'b0;
            state        <= ST_NEXT;
            if (!cur_we) begin
              wb_valid <= 1'b1;
              wb_idx   <= cur_dest;
              wb_data  <= lane_ld;
            end
          end else if (tmo_cnt == TMO_W'(ACK_TIMEOUT - 1)) begin
            pending[cur] <= 1'b0;
            timeout_err  <= 1'b1;
            state        <= ST_NEXT;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        ST_NEXT: begin
          tmo_cnt <= '0;
          state   <= (|pending) ? ST_ISSUE : ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vliw_lsu.sv
// Bench for vliw_lsu: directed bundles plus random bundles against a
// byte-level memory model that predicts transactions and writebacks.
module tb_vliw_lsu;
  import vliw_lsu_pkg::*;

  logic        wb_clk_i = 1'b0;
  logic        rst_n    = 1'b0;
  logic [2:0]  req_valid, req_we, req_sext;
  logic [95:0] req_addr, req_wdata;
  logic [5:0]  req_size;
  logic [14:0] req_dest;
  logic        busy, wb_valid, misalign_err, timeout_err;
  logic [4:0]  wb_idx;
  logic [31:0] wb_data;

  always #5 wb_clk_i = ~wb_clk_i;

  vliw_lsu_if mif ();

  vliw_lsu dut (
    .wb_clk_i     (wb_clk_i),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_size     (req_size),
    .req_sext     (req_sext),
    .req_dest     (req_dest),
    .busy         (busy),
    .mem          (mif),
    .wb_valid     (wb_valid),
    .wb_idx       (wb_idx),
    .wb_data      (wb_data),
    .misalign_err (misalign_err),
    .timeout_err  (timeout_err)
  );

  typedef struct packed {
    logic        we;
    logic [29:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } txn_t;

  typedef struct packed {
    logic [4:0]  idx;
    logic [31:0] data;
  } wb_t;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]  ref_mem [0:1023];
  logic [31:0] dut_mem [0:255];
  txn_t exp_txn [$];
  wb_t  exp_wb  [$];
  int   exp_mis, exp_tmo, obs_mis, obs_tmo, obs_txn, req_cycles;
  bit   no_ack = 1'b0, rand_delay = 1'b0, force_ack = 1'b0;
  int   wait_cnt = 0, cur_delay = 0;
  txn_t last_txn;
  wb_t  last_wb;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Memory responder and output monitor; everything is sampled mid-cycle.
  always @(negedge wb_clk_i) begin : mon
    txn_t t, e;
    wb_t  w;
    mif.mem_ack   = 1'b0;
    mif.mem_rdata = $urandom;
    if (wb_valid) begin
      last_wb = {wb_idx, wb_data};
      if (exp_wb.size() == 0) chk("wb_extra", 64'(1), 64'(0));
      else begin
        w = exp_wb.pop_front();
        chk("wb_idx", 64'(wb_idx), 64'(w.idx));
        chk("wb_data", 64'(wb_data), 64'(w.data));
      end
    end
    if (misalign_err) obs_mis++;
    if (timeout_err) obs_tmo++;
    if (!mif.mem_req) wait_cnt = 0;
    else begin
      req_cycles++;
      if (!no_ack && wait_cnt >= cur_delay) begin
        mif.mem_ack = 1'b1;
        obs_txn++;
        wait_cnt  = 0;
        cur_delay = rand_delay ? int'($urandom_range(0, 3)) : 0;
        t = {mif.mem_we, mif.mem_addr, mif.mem_wdata, mif.mem_wmask};
        last_txn = t;
        if (t.we) begin
          for (int k = 0; k < 4; k++)
            if (t.wmask[k]) dut_mem[t.waddr[7:0]][8*k +: 8] = t.wdata[8*k +: 8];
        end else begin
          mif.mem_rdata = dut_mem[t.waddr[7:0]];
        end
        if (exp_txn.size() == 0) chk("txn_extra", 64'(1), 64'(0));
        else begin
          e = exp_txn.pop_front();
          chk("txn_we", 64'(t.we), 64'(e.we));
          chk("txn_addr", 64'(t.waddr), 64'(e.waddr));
          if (e.we) begin
            chk("txn_wmask", 64'(t.wmask), 64'(e.wmask));
            chk("txn_wdata", 64'(t.wdata), 64'(e.wdata));
          end
        end
      end else begin
        wait_cnt++;
      end
    end
    if (force_ack) mif.mem_ack = 1'b1;
  end

  // Reference: walk the bundle's slots in order over a byte-addressed memory.
  task automatic ref_bundle();
    logic [31:0] a, d, v;
    logic [1:0]  sz;
    int          nb;
    txn_t        t;
    wb_t         w;
    for (int s = 0; s < 3; s++) begin
      if (req_valid[s]) begin
        a  = req_addr[32*s +: 32];
        d  = req_wdata[32*s +: 32];
        sz = req_size[2*s +: 2];
        nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        if (sz == 2'd3 || (a % nb) != 0) exp_mis = 1;
        else if (no_ack) exp_tmo++;
        else begin
          t.we    = req_we[s];
          t.waddr = 30'(a / 4);
          t.wmask = '0;
          t.wdata = '0;
          if (req_we[s]) begin
            t.wmask = 4'(((1 << nb) - 1) << (a % 4));
            t.wdata = (nb == 1) ? d[7:0] * 32'h0101_0101 :
                      (nb == 2) ? d[15:0] * 32'h0001_0001 : d;
            for (int k = 0; k < nb; k++) ref_mem[a + k] = 8'(d >> (8 * k));
          end else begin
            v = 0;
            for (int k = 0; k < nb; k++) v = v + (32'(ref_mem[a + k]) << (8 * k));
            if (req_sext[s] && nb < 4 && v >= (32'd1 << (8 * nb - 1)))
              v = v - (32'd1 << (8 * nb));
            w.idx  = req_dest[5*s +: 5];
            w.data = v;
            exp_wb.push_back(w);
          end
          exp_txn.push_back(t);
        end
      end
    end
  endtask

  task automatic step();
    @(negedge wb_clk_i);
    #1;
  endtask

  task automatic clear_slots();
    req_valid = '0;
    req_we    = 3'($urandom);
    req_sext  = 3'($urandom);
    req_addr  = {$urandom, $urandom, $urandom};
    req_wdata = {$urandom, $urandom, $urandom};
    req_size  = 6'($urandom);
    req_dest  = 15'($urandom);
  endtask

  task automatic set_slot(input int s, input bit we, input logic [31:0] a, input logic [31:0] d,
                          input logic [1:0] sz, input bit sx, input logic [4:0] dst);
    req_valid[s]          = 1'b1;
    req_we[s]             = we;
    req_addr[32*s +: 32]  = a;
    req_wdata[32*s +: 32] = d;
    req_size[2*s +: 2]    = sz;
    req_sext[s]           = sx;
    req_dest[5*s +: 5]    = dst;
  endtask

  task automatic set_word(input int byte_addr, input logic [31:0] val);
    dut_mem[byte_addr / 4] = val;
    for (int k = 0; k < 4; k++) ref_mem[byte_addr + k] = 8'(val >> (8 * k));
  endtask

  task automatic reset_counts();
    exp_txn.delete();
    exp_wb.delete();
    exp_mis = 0; exp_tmo = 0; obs_mis = 0; obs_tmo = 0; obs_txn = 0; req_cycles = 0;
  endtask

  // Inputs are scrambled every busy cycle; the DUT must ignore them.
  task automatic wait_idle(input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      step();
      if (!busy) done = 1'b1;
      else clear_slots();
      if (busy) req_valid = 3'($urandom);
    end
    req_valid = '0;
    chk("busy_bound", 64'(done), 64'(1));
  endtask

  task automatic end_checks();
    chk("txn_left", 64'(exp_txn.size()), 64'(0));
    chk("wb_left", 64'(exp_wb.size()), 64'(0));
    chk("misalign_cnt", 64'(obs_mis), 64'(exp_mis));
    chk("timeout_cnt", 64'(obs_tmo), 64'(exp_tmo));
  endtask

  task automatic fire(input int budget);
    reset_counts();
    ref_bundle();
    wait_idle(budget);
    end_checks();
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [31:0] a;
    logic [1:0]  sz;
    int          nb, pick;
    for (int w = 0; w < 256; w++) set_word(4 * w, $urandom);
    clear_slots();
    reset_counts();
    step(); step();
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_mem_req", 64'(mif.mem_req), 64'(0));
    chk("rst_wb_valid", 64'(wb_valid), 64'(0));
    chk("rst_misalign", 64'(misalign_err), 64'(0));
    chk("rst_timeout", 64'(timeout_err), 64'(0));
    rst_n = 1'b1;
    step();

    // Single signed byte load, exact cycle timing.
    set_word(32'h100, 32'h80A5_5A3C);
    clear_slots();
    set_slot(0, 1'b0, 32'h103, 32'h0, SZ_BYTE, 1'b1, 5'd7);
    reset_counts();
    ref_bundle();
    step();
    req_valid = '0;
    chk("t1_busy", 64'(busy), 64'(1));
    chk("t1_mem_req", 64'(mif.mem_req), 64'(1));
    chk("t1_mem_addr", 64'(mif.mem_addr), 64'h40);
    step();
    chk("t2_wb_valid", 64'(wb_valid), 64'(1));
    chk("t2_wb_idx", 64'(wb_idx), 64'(7));
    chk("t2_wb_data", 64'(wb_data), 64'hFFFF_FF80);
    step();
    chk("t3_busy", 64'(busy), 64'(0));
    end_checks();

    // Store word then half load of the same word from slot2.
    clear_slots();
    set_slot(0, 1'b1, 32'h200, 32'hDEAD_BEEF, SZ_WORD, 1'b0, 5'd0);
    set_slot(2, 1'b0, 32'h202, 32'h0, SZ_HALF, 1'b0, 5'd3);
    fire(50);
    chk("b2_txn_cnt", 64'(obs_txn), 64'(2));
    chk("b2_wb_data", 64'(last_wb.data), 64'h0000_DEAD);
    chk("b2_wb_idx", 64'(last_wb.idx), 64'(3));

    // Misaligned half in slot1 is dropped; slot0 byte store proceeds.
    clear_slots();
    set_slot(0, 1'b1, 32'h10, 32'h0000_00AB, SZ_BYTE, 1'b0, 5'd0);
    set_slot(1, 1'b0, 32'h101, 32'h0, SZ_HALF, 1'b0, 5'd4);
    fire(50);
    chk("b3_txn_cnt", 64'(obs_txn), 64'(1));
    chk("b3_wmask", 64'(last_txn.wmask), 64'h1);
    chk("b3_wdata", 64'(last_txn.wdata), 64'hABAB_ABAB);

    // Ack never arrives: one slot, then two slots.
    no_ack = 1'b1;
    clear_slots();
    set_slot(1, 1'b0, 32'h21, 32'h0, SZ_BYTE, 1'b1, 5'd9);
    fire(400);
    chk("tmo1_req_cycles", 64'(req_cycles), 64'(255));
    clear_slots();
    set_slot(0, 1'b1, 32'h40, 32'h1234_5678, SZ_WORD, 1'b0, 5'd0);
    set_slot(2, 1'b0, 32'h46, 32'h0, SZ_HALF, 1'b1, 5'd5);
    fire(700);
    chk("tmo2_req_cycles", 64'(req_cycles), 64'(510));

    // Reset during ISSUE of a 3-slot bundle, then rerun it.
    clear_slots();
    set_slot(0, 1'b1, 32'h300, 32'h1111_2222, SZ_WORD, 1'b0, 5'd0);
    set_slot(1, 1'b0, 32'h300, 32'h0, SZ_WORD, 1'b0, 5'd1);
    set_slot(2, 1'b0, 32'h301, 32'h0, SZ_BYTE, 1'b1, 5'd2);
    reset_counts();
    step();
    req_valid = '0;
    step(); step();
    chk("rst_mid_req_before", 64'(mif.mem_req), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("rst_mid_req", 64'(mif.mem_req), 64'(0));
    chk("rst_mid_busy", 64'(busy), 64'(0));
    step();
    rst_n  = 1'b1;
    no_ack = 1'b0;
    step();
    req_valid = 3'b111;
    fire(50);
    chk("rst_rerun_txn_cnt", 64'(obs_txn), 64'(3));

    // Stray ack while idle.
    reset_counts();
    clear_slots();
    force_ack = 1'b1;
    step();
    force_ack = 1'b0;
    step();
    chk("idle_ack_busy", 64'(busy), 64'(0));
    chk("idle_ack_txn", 64'(obs_txn), 64'(0));
    chk("idle_ack_wb", 64'(wb_valid), 64'(0));

    // Random bundles with random ack latency.
    rand_delay = 1'b1;
    for (int b = 0; b < 40; b++) begin
      clear_slots();
      for (int s = 0; s < 3; s++) begin
        if ($urandom_range(0, 3) != 0) begin
          pick = int'($urandom_range(0, 7));
          sz   = (pick == 7) ? SZ_ILLEGAL : (pick > 2) ? SZ_WORD : 2'(pick);
          nb   = (sz == SZ_BYTE) ? 1 : (sz == SZ_HALF) ? 2 : 4;
          a    = (b % 2 == 1) ? $urandom_range(0, 31) : $urandom_range(0, 1020);
          if ($urandom_range(0, 3) != 0) a = a - (a % nb);
          set_slot(s, 1'($urandom), a, $urandom, sz, 1'($urandom), 5'($urandom));
        end
      end
      fire(100);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
